// File: rtl/exp_accum_pkg.sv
// Shared types and constants for the exponential-unit frame accumulator.
package exp_accum_pkg;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} acc_state_t;

  localparam int EXP_W    = 20;
  localparam int EXP_FRAC = 4;

endpackage

// File: rtl/exp_frame_accum_valid_delay_line.sv
// valid_delay_line: LAT-stage {valid, last} shift register matched to the exponential unit latency.
module valid_delay_line #(
  parameter int LAT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] iBits,
  output logic [1:0] oTap,
  output logic       oAnyValidNext
);

  logic [LAT-1:0][1:0] stages;

  // Shift every cycle; the upstream unit never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {LAT{2'b00}};
    end else begin
      stages[0] <= iBits;
      for (int i = 1; i < LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  // Valid bits the line will hold after the next edge, so busy can be registered in step.
  always_comb begin
    oAnyValidNext = iBits[1];
    for (int i = 0; i < LAT - 1; i++) begin
      oAnyValidNext = oAnyValidNext | stages[i][1];
    end
  end

  assign oTap = stages[LAT-1];

endmodule

// File: rtl/exp_frame_accum.sv
// exp_frame_accum: sums exponential-unit outputs over a frame (softmax denominator).
// Define EXP_FRAME_ACCUM_SAT_EN for a saturating accumulator with overflow reporting.
module exp_frame_accum
  import exp_accum_pkg::*;
#(
  parameter int LAT   = 6,
  parameter int ACC_W = 28,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iValid,
  input  logic             iLast,
  input  logic [EXP_W-1:0] iExpData,
  output logic [ACC_W-1:0] oSum,
  output logic [CNT_W-1:0] oCount,
  output logic             oSumValid,
  input  logic             iSumReady,
  output logic             oBusy,
  output logic             oOverflow,
  output logic             oOverrun
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accBase;
  logic [ACC_W-1:0] accNext;
  logic [ACC_W-1:0] expExt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countBase;
  logic [CNT_W-1:0] countNext;
  logic [1:0]       tap;
  logic             tapV;
  logic             tapL;
  logic             frameDone;
  logic             anyValidNext;
  logic             frameOvfNext;
  logic             accumNext;
`ifdef EXP_FRAME_ACCUM_SAT_EN
  logic [ACC_W:0]   sumWide;
  logic             frameOvf;
`endif

  valid_delay_line #(.LAT(LAT)) uDelay (
    .clk           (clk),
    .rst_n         (rst_n),
    .iBits         ({iValid, iLast & iValid}),
    .oTap          (tap),
    .oAnyValidNext (anyValidNext)
  );

  assign tapV      = tap[1];
  assign tapL      = tap[0];
  assign frameDone = tapV & tapL;

  // Running sum/count including the sample on the tap; IDLE starts a fresh frame.
  always_comb begin
    expExt    = ACC_W'(iExpData);
    accBase   = (state == ACCUM) ? acc : {ACC_W{1'b0}};
    countBase = (state == ACCUM) ? count : {CNT_W{1'b0}};
`ifdef EXP_FRAME_ACCUM_SAT_EN
    sumWide = {1'b0, accBase} + {1'b0, expExt};
    if (sumWide[ACC_W]) begin
      accNext      = {ACC_W{1'b1}};
      frameOvfNext = 1'b1;
    end else begin
      accNext      = sumWide[ACC_W-1:0];
      frameOvfNext = (state == ACCUM) & frameOvf;
    end
`else
    accNext      = accBase + expExt;
    frameOvfNext = 1'b0;
`endif
    if (&countBase) begin
      countNext = countBase;
    end else begin
      countNext = countBase + CNT_W'(1'b1);
    end
    if (tapV) begin
      accumNext = ~tapL;
    end else begin
      accumNext = (state == ACCUM);
    end
  end

  // Frame FSM, accumulator and the result register with its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= {ACC_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      oSum      <= {ACC_W{1'b0}};
      oCount    <= {CNT_W{1'b0}};
      oSumValid <= 1'b0;
      oBusy     <= 1'b0;
      oOverflow <= 1'b0;
      oOverrun  <= 1'b0;
`ifdef EXP_FRAME_ACCUM_SAT_EN
      frameOvf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    state <= (tapV && !tapL) ? ACCUM : IDLE;
        ACCUM:   state <= (tapV && tapL) ? IDLE : ACCUM;
        default: state <= IDLE;
      endcase
      if (tapV) begin
        acc      <= accNext;
        count    <= countNext;
`ifdef EXP_FRAME_ACCUM_SAT_EN
        frameOvf <= frameOvfNext;
`endif
      end
      // A completion into a held, unaccepted result is dropped and flagged.
      if (frameDone && (!oSumValid || iSumReady)) begin
        oSum      <= accNext;
        oCount    <= countNext;
        oOverflow <= frameOvfNext;
        oSumValid <= 1'b1;
      end else if (frameDone) begin
        oOverrun  <= 1'b1;
      end else if (iSumReady) begin
        oSumValid <= 1'b0;
      end
      oBusy <= accumNext | anyValidNext;
    end
  end

endmodule

// File: tb/tb_exp_frame_accum.sv
// Directed testbench for exp_frame_accum; a registered stub stands in for the exponential unit.
module tb_exp_frame_accum;

  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iValid;
  logic        iLast;
  logic        iSumReady;
  logic [19:0] expIn;
  logic [19:0] iExpData;
  logic [19:0] expPipe [LAT];

  logic [27:0] oSum;
  logic [8:0]  oCount;
  logic        oSumValid, oBusy, oOverflow, oOverrun;
  logic [19:0] oSum2;
  logic [8:0]  oCount2;
  logic        oSumValid2, oBusy2, oOverflow2, oOverrun2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Exponential-unit stand-in: fixed LAT-cycle pipeline; values driven are the exp outputs.
  always @(posedge clk) begin
    expPipe[0] <= expIn;
    for (int i = 1; i < LAT; i++) expPipe[i] <= expPipe[i-1];
  end
  assign iExpData = expPipe[LAT-1];

  exp_frame_accum #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .iLast(iLast), .iExpData(iExpData),
    .oSum(oSum), .oCount(oCount), .oSumValid(oSumValid), .iSumReady(iSumReady),
    .oBusy(oBusy), .oOverflow(oOverflow), .oOverrun(oOverrun)
  );

  exp_frame_accum #(.LAT(LAT), .ACC_W(20)) dutNarrow (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .iLast(iLast), .iExpData(iExpData),
    .oSum(oSum2), .oCount(oCount2), .oSumValid(oSumValid2), .iSumReady(iSumReady),
    .oBusy(oBusy2), .oOverflow(oOverflow2), .oOverrun(oOverrun2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int n, input logic [19:0] v);
    for (int i = 0; i < n; i++) begin
      iValid = 1'b1;
      iLast  = (i == n - 1);
      expIn  = v;
      tick();
    end
    iValid = 1'b0;
    iLast  = 1'b0;
    expIn  = 20'h0;
  endtask

  task automatic waitSum(output int n);
    n = 0;
    while (!oSumValid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iValid = 1'b0; iLast = 1'b0; iSumReady = 1'b0; expIn = 20'h0;
    tick();
    tick();
    compared++; if ({oSumValid, oBusy, oOverflow, oOverrun} !== 4'b0000) begin mismatched++; $display("FAIL reset_flags: got %b expected 0000", {oSumValid, oBusy, oOverflow, oOverrun}); end
    compared++; if (oSum !== 28'd0 || oCount !== 9'd0) begin mismatched++; $display("FAIL reset_data: got sum %0d count %0d expected 0 0", oSum, oCount); end
    compared++; if (oSumValid2 !== 1'b0) begin mismatched++; $display("FAIL reset_narrow_valid: got %b expected 0", oSumValid2); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_four_samples;
    int n;
    iSumReady = 1'b1;
    sendFrame(4, 20'h10);
    compared++; if (oBusy !== 1'b1) begin mismatched++; $display("FAIL four_busy: got %b expected 1", oBusy); end
    waitSum(n);
    compared++; if (n !== 6) begin mismatched++; $display("FAIL four_latency: got %0d cycles after t+1 expected 6", n); end
    compared++; if (oSum !== 28'd64) begin mismatched++; $display("FAIL four_sum: got %0d expected 64", oSum); end
    compared++; if (oCount !== 9'd4) begin mismatched++; $display("FAIL four_count: got %0d expected 4", oCount); end
    tick();
    compared++; if (oSumValid !== 1'b0) begin mismatched++; $display("FAIL four_pulse: got %b expected 0", oSumValid); end
    compared++; if (oBusy !== 1'b0) begin mismatched++; $display("FAIL four_idle: got %b expected 0", oBusy); end
  endtask

  task automatic test_single;
    int n;
    iSumReady = 1'b1;
    sendFrame(1, 20'h10);
    waitSum(n);
    compared++; if (n !== 6) begin mismatched++; $display("FAIL single_latency: got %0d expected 6", n); end
    compared++; if (oSum !== 28'd16 || oCount !== 9'd1) begin mismatched++; $display("FAIL single_result: got %0d/%0d expected 16/1", oSum, oCount); end
    tick();
  endtask

  task automatic test_back_to_back_overrun;
    iSumReady = 1'b0;
    sendFrame(2, 20'h10);
    sendFrame(2, 20'h18);
    for (int i = 0; i < 8; i++) tick();
    compared++; if (oSumValid !== 1'b1) begin mismatched++; $display("FAIL overrun_valid: got %b expected 1", oSumValid); end
    compared++; if (oSum !== 28'd32 || oCount !== 9'd2) begin mismatched++; $display("FAIL overrun_held: got %0d/%0d expected 32/2", oSum, oCount); end
    compared++; if (oOverrun !== 1'b1) begin mismatched++; $display("FAIL overrun_flag: got %b expected 1", oOverrun); end
    compared++; if (oOverrun2 !== 1'b1) begin mismatched++; $display("FAIL overrun_flag_narrow: got %b expected 1", oOverrun2); end
    iSumReady = 1'b1;
    tick();
    compared++; if (oSumValid !== 1'b0) begin mismatched++; $display("FAIL overrun_consume: got %b expected 0", oSumValid); end
    compared++; if (oOverrun !== 1'b1) begin mismatched++; $display("FAIL overrun_sticky: got %b expected 1", oOverrun); end
  endtask

  task automatic test_same_cycle;
    int n;
    doReset();
    iSumReady = 1'b0;
    sendFrame(1, 20'h10);
    waitSum(n);
    sendFrame(2, 20'h20);
    for (int i = 0; i < 5; i++) tick();
    compared++; if (oSumValid !== 1'b1 || oSum !== 28'd16) begin mismatched++; $display("FAIL same_held: got %b/%0d expected 1/16", oSumValid, oSum); end
    iSumReady = 1'b1;
    tick();
    compared++; if (oSumValid !== 1'b1) begin mismatched++; $display("FAIL same_valid: got %b expected 1", oSumValid); end
    compared++; if (oSum !== 28'd64 || oCount !== 9'd2) begin mismatched++; $display("FAIL same_result: got %0d/%0d expected 64/2", oSum, oCount); end
    compared++; if (oOverrun !== 1'b0) begin mismatched++; $display("FAIL same_no_overrun: got %b expected 0", oOverrun); end
    tick();
    compared++; if (oSumValid !== 1'b0) begin mismatched++; $display("FAIL same_consumed: got %b expected 0", oSumValid); end
  endtask

  task automatic test_overflow;
    int n;
    logic [19:0] expSum2;
    logic        expOvf2;
`ifdef EXP_FRAME_ACCUM_SAT_EN
    expSum2 = 20'hFFFFF;
    expOvf2 = 1'b1;
`else
    expSum2 = 20'hFFFFE;
    expOvf2 = 1'b0;
`endif
    doReset();
    iSumReady = 1'b1;
    sendFrame(2, 20'hFFFFF);
    waitSum(n);
    compared++; if (oSum !== 28'h01FFFFE || oOverflow !== 1'b0) begin mismatched++; $display("FAIL ovf_wide: got %0h/%b expected 1fffffe/0", oSum, oOverflow); end
    compared++; if (oSumValid2 !== 1'b1 || oCount2 !== 9'd2) begin mismatched++; $display("FAIL ovf_narrow_valid: got %b/%0d expected 1/2", oSumValid2, oCount2); end
    compared++; if (oSum2 !== expSum2) begin mismatched++; $display("FAIL ovf_narrow_sum: got %0h expected %0h", oSum2, expSum2); end
    compared++; if (oOverflow2 !== expOvf2) begin mismatched++; $display("FAIL ovf_narrow_flag: got %b expected %b", oOverflow2, expOvf2); end
    tick();
    compared++; if (oBusy2 !== 1'b0) begin mismatched++; $display("FAIL ovf_narrow_idle: got %b expected 0", oBusy2); end
  endtask

  task automatic test_reset_midframe;
    int n;
    iSumReady = 1'b0;
    sendFrame(1, 20'h10);
    waitSum(n);
    for (int i = 0; i < 3; i++) begin
      iValid = 1'b1; iLast = 1'b0; expIn = 20'h10;
      tick();
    end
    iValid = 1'b0;
    compared++; if (oBusy !== 1'b1 || oSumValid !== 1'b1) begin mismatched++; $display("FAIL mid_pre: got busy %b valid %b expected 1 1", oBusy, oSumValid); end
    rst_n = 1'b0;
    #1;
    compared++; if ({oSumValid, oBusy, oOverflow, oOverrun} !== 4'b0000) begin mismatched++; $display("FAIL mid_flags: got %b expected 0000", {oSumValid, oBusy, oOverflow, oOverrun}); end
    compared++; if (oSum !== 28'd0 || oCount !== 9'd0) begin mismatched++; $display("FAIL mid_data: got %0d/%0d expected 0/0", oSum, oCount); end
    tick();
    tick();
    rst_n = 1'b1;
    iSumReady = 1'b1;
    tick();
    compared++; if (oBusy !== 1'b0) begin mismatched++; $display("FAIL mid_flushed: got %b expected 0", oBusy); end
    sendFrame(2, 20'h10);
    waitSum(n);
    compared++; if (n !== 6) begin mismatched++; $display("FAIL mid_latency: got %0d expected 6", n); end
    compared++; if (oSum !== 28'd32 || oCount !== 9'd2) begin mismatched++; $display("FAIL mid_after: got %0d/%0d expected 32/2", oSum, oCount); end
  endtask

  initial begin
    test_reset();
    test_four_samples();
    test_single();
    test_back_to_back_overrun();
    test_same_cycle();
    test_overflow();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/exp_frame_accum.md
# exp_frame_accum

Downstream stage of the pipelined Taylor exponential unit. It accumulates the unit's exponential outputs over a frame of samples, which forms the softmax denominator. The exponential unit drives no usable output valid, so this block carries its own valid/last delay line, matched to the unit's fixed latency, to tell which `iExpData` cycles are real samples. Each completed frame produces one registered sum and sample count, presented on a valid/ready output handshake.

## Interface
- `LAT`, 6, exponential unit latency in cycles, from its data input to its data output; legal range 1..16.
- `ACC_W`, 28, accumulator width (Q(ACC_W-4).4, unsigned); minimum 20.
- `CNT_W`, 9, sample-counter width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iValid`  in  1  sample presented to the exponential unit this cycle; same cycle as that unit's data input.
- `iLast`  in  1  last sample of the frame; qualified by `iValid`.
- `iExpData`  in  20  exponential unit output, unsigned Q16.4.
- `oSum`  out  ACC_W  frame sum, Q(ACC_W-4).4.
- `oCount`  out  CNT_W  number of samples in the frame.
- `oSumValid`  out  1  `oSum`/`oCount` hold a result.
- `iSumReady`  in  1  consumer accepts the result.
- `oBusy`  out  1  a frame is being accumulated, or samples are still in the delay line.
- `oOverflow`  out  1  the held result saturated.
- `oOverrun`  out  1  sticky; a result was dropped.

## Operation
- **Delay line.** `{iValid, iLast & iValid}` shifts through LAT registered stages. The tap at stage LAT-1 is `tapV`/`tapL`. The unit has no stall, so the delay line shifts every cycle.
- **Sample acceptance.** `iExpData` is sampled only on cycles where `tapV`=1.
- **FSM, two states.**
  - IDLE → ACCUM when `tapV`=1 and `tapL`=0. The accumulator loads `iExpData` and the count loads 1.
  - ACCUM, with `tapV`=1: acc += `iExpData`, count += 1.
  - ACCUM → IDLE when `tapV`=1 and `tapL`=1, after that last sample is added.
  - IDLE with `tapV`=1 and `tapL`=1 is a single-sample frame. The result is `iExpData` with count 1, and the state stays IDLE.
- **Arithmetic.** `iExpData` is zero-extended to ACC_W. The count saturates at all-ones.
- **Result register.** Loaded on frame completion with the final acc, the final count and the overflow status; `oSumValid` sets to 1.
  - The result is held stable while `oSumValid`=1 and `iSumReady`=0.
  - `oSumValid`=1 and `iSumReady`=1 clears `oSumValid`, unless a new completion occurs in the same cycle. In that case the new result loads and `oSumValid` stays 1; this is not an overrun.
  - A completion while `oSumValid`=1 and `iSumReady`=0 drops the new result: the held result is unchanged and `oOverrun` is set.
  - Accumulation of the following frame is never blocked by the result register.
- **`oBusy`** = (state==ACCUM) OR any delay-line valid bit set.
- **Reset** (any time, including mid-frame): every output is 0, the FSM goes to IDLE, acc and count are 0, the delay line is cleared, and `oOverrun` is cleared. Samples in flight inside the exponential unit at reset are discarded. Reset is the only way to clear `oOverrun`.

## Timing
- The delay-line tap asserts exactly LAT cycles after `iValid`, aligned with the corresponding `iExpData`.
- The last sample is presented with `iValid`=`iLast`=1 in cycle t. `oSumValid` rises in cycle t+LAT+1.
- Back-to-back frames are supported at full rate: a new frame may start on the cycle after the last sample of the previous one is accepted.
- Every output is registered; there is no combinational path from input to output.

## Configuration
- `EXP_FRAME_ACCUM_SAT_EN` defined: the accumulator saturates at 2^ACC_W-1. The frame's overflow flag sets when a saturating add occurs, and is carried into `oOverflow` with the result.
- `EXP_FRAME_ACCUM_SAT_EN` undefined: the accumulator wraps modulo 2^ACC_W, and `oOverflow` is tied to 0.

## Structure
- Package `exp_accum_pkg` holds:
  - `typedef enum logic {IDLE, ACCUM} acc_state_t`
  - `localparam EXP_W = 20`
  - `localparam EXP_FRAC = 4`
- Sub-module `valid_delay_line`: a parameterised LAT-stage, 2-bit shift register with asynchronous reset, used for `{valid, last}`.

## Test plan
- Four samples of 0x000, with `iLast` on the fourth; exponential unit in the loop, `iSumReady`=1 → `oSum`=64 (4×16), `oCount`=4, `oSumValid` pulses one cycle at t+7.
- Single-sample frame: `iValid`=`iLast`=1 with input 0x000 → `oSum`=16, `oCount`=1.
- Two back-to-back 2-sample frames, `iSumReady`=0 until after the second completes → first result (32, 2) held, `oOverrun`=1. Then assert `iSumReady`: the same result is consumed.
- Completion in the same cycle as `iSumReady`=1 with `oSumValid`=1 → new result loads, `oSumValid` stays 1, `oOverrun`=0.
- ACC_W=20 with macro defined; drive `iExpData`=0xFFFFF for two samples → `oSum`=0xFFFFF, `oOverflow`=1. Macro undefined → `oSum`=0xFFFFE, `oOverflow`=0.
- Reset asserted mid-frame, after 3 of 5 samples → all outputs 0, `oBusy`=0. A following 2-sample frame of 0x000 gives 32, 2.
